// File: rtl/map_controller.sv
// rtl/map_controller.sv - playfield wall map and debounced map-select controller
module map_controller #(
  parameter  int WIDTH    = 16,
  parameter  int HEIGHT   = 12,
  parameter  int NUM_MAPS = 4,
  parameter  int LOCKOUT  = 1000000,
  localparam int XW       = $clog2(WIDTH),
  localparam int YW       = $clog2(HEIGHT),
  localparam int MW       = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          next_map_btn_i,
  input  logic          start_i,
  input  logic          game_over_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic          wall_o,
  output logic [MW-1:0] map_idx_o,
  output logic          playing_o,
  output logic          restart_o
);

  localparam int LCW = $clog2(LOCKOUT + 1);

  // Geometry constants widened to 32 bits so coordinate compares stay unsigned.
  localparam logic [31:0] X_LAST  = 32'(WIDTH - 1);
  localparam logic [31:0] Y_LAST  = 32'(HEIGHT - 1);
  localparam logic [31:0] X_LIM   = 32'(WIDTH);
  localparam logic [31:0] Y_LIM   = 32'(HEIGHT);
  localparam logic [31:0] H_ROW   = 32'(HEIGHT / 2);
  localparam logic [31:0] H_X_LO  = 32'(WIDTH / 4);
  localparam logic [31:0] H_X_HI  = 32'((3 * WIDTH) / 4);
  localparam logic [31:0] V_COL   = 32'(WIDTH / 2);
  localparam logic [31:0] V_Y_LO  = 32'(HEIGHT / 4);
  localparam logic [31:0] V_Y_HI  = 32'((3 * HEIGHT) / 4);
  localparam logic [MW-1:0] MAP_LAST = MW'(NUM_MAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  logic           s1_q, s2_q, s3_q;
  logic [LCW-1:0] lc_q, lc_d;
  state_e         state_q, state_d;
  logic [MW-1:0]  map_q, map_d;
  logic           playing_q, playing_d;
  logic           restart_q, restart_d;
  logic           press;
  logic           accept;
  logic           load_lc;
  logic [MW-1:0]  map_next;
  logic [31:0]    x_ext, y_ext;
  logic           border, obs_h, obs_v;

  // Button synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= next_map_btn_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign press    = s2_q & ~s3_q;
  assign accept   = press && (lc_q == '0);
  assign map_next = (map_q == MAP_LAST) ? '0 : map_q + MW'(1);

  // Next-state logic: map stepping, restart pulse and lockout reload.
  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    restart_d = 1'b0;
    load_lc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          // A simultaneous press is swallowed but still arms the lockout.
          state_d = PLAY;
          load_lc = accept;
        end else if (accept) begin
          map_d     = map_next;
          restart_d = 1'b1;
          load_lc   = 1'b1;
        end
      end
      PLAY: begin
        if (game_over_i) begin
          state_d = OVER;
        end
      end
      OVER: begin
        if (accept) begin
          state_d   = IDLE;
          restart_d = 1'b1;
          load_lc   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_lc) begin
      lc_d = LCW'(LOCKOUT);
    end else if (lc_q != '0) begin
      lc_d = lc_q - LCW'(1);
    end else begin
      lc_d = lc_q;
    end

    playing_d = (state_d == PLAY);
  end

  // State, map, lockout and registered output flops.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      map_q     <= '0;
      lc_q      <= '0;
      playing_q <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      lc_q      <= lc_d;
      playing_q <= playing_d;
      restart_q <= restart_d;
    end
  end

  // Wall flag: border, out-of-range pixels and map-dependent obstacles.
  always_comb begin
    x_ext  = 32'(x_i);
    y_ext  = 32'(y_i);
    border = (x_ext == 32'd0) || (x_ext == X_LAST) ||
             (y_ext == 32'd0) || (y_ext == Y_LAST) ||
             (x_ext >= X_LIM) || (y_ext >= Y_LIM);
    // Map 1 and 3 share the horizontal bar, maps 2 and 3 the vertical one.
    obs_h  = map_q[0] && (y_ext == H_ROW) && (x_ext >= H_X_LO) && (x_ext < H_X_HI);
    obs_v  = map_q[1] && (x_ext == V_COL) && (y_ext >= V_Y_LO) && (y_ext < V_Y_HI);
    wall_o = border || obs_h || obs_v;
  end

  assign map_idx_o = map_q;
  assign playing_o = playing_q;
  assign restart_o = restart_q;

endmodule

// File: tb/tb_map_controller.sv
// tb/tb_map_controller.sv - directed self-checking bench for map_controller
module tb_map_controller;

  logic       clk;
  logic       reset;
  logic       btn;
  logic       start;
  logic       game_over;
  logic [3:0] x;
  logic [3:0] y;
  logic       wall;
  logic [1:0] map_idx;
  logic       playing;
  logic       restart;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  map_controller #(
    .WIDTH(16), .HEIGHT(12), .NUM_MAPS(4), .LOCKOUT(4)
  ) dut (
    .clk_i(clk), .reset_i(reset), .next_map_btn_i(btn), .start_i(start),
    .game_over_i(game_over), .x_i(x), .y_i(y), .wall_o(wall),
    .map_idx_o(map_idx), .playing_o(playing), .restart_o(restart)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn = 1'b0; start = 1'b0; game_over = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    btn = 1'b0; start = 1'b0; game_over = 1'b0; x = 4'd0; y = 4'd5;
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (map_idx !== 2'd0) begin n_fail++; $display("FAIL reset_map: got %0d expected 0", map_idx); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %0b expected 0", playing); end
    n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL reset_restart: got %0b expected 0", restart); end
    x = 4'd0; y = 4'd5; #1;
    n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL reset_wall_left: got %0b expected 1", wall); end
    x = 4'd5; y = 4'd5; #1;
    n_checks++; if (wall !== 1'b0) begin n_fail++; $display("FAIL reset_wall_open: got %0b expected 0", wall); end
    x = 4'd15; y = 4'd5; #1;
    n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL reset_wall_right: got %0b expected 1", wall); end
    x = 4'd5; y = 4'd11; #1;
    n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL reset_wall_bottom: got %0b expected 1", wall); end
    x = 4'd5; y = 4'd12; #1;
    n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL reset_wall_oor: got %0b expected 1", wall); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    btn = 1'b1;
    tick();
    n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL hold_e1: got %0b expected 0", restart); end
    tick();
    n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL hold_e2: got %0b expected 0", restart); end
    tick();
    n_checks++; if (restart !== 1'b1) begin n_fail++; $display("FAIL hold_e3_restart: got %0b expected 1", restart); end
    n_checks++; if (map_idx !== 2'd1) begin n_fail++; $display("FAIL hold_e3_map: got %0d expected 1", map_idx); end
    cnt = 0;
    repeat (7) begin tick(); cnt += int'(restart); end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL hold_single: got %0d extra restarts expected 0", cnt); end
    n_checks++; if (map_idx !== 2'd1) begin n_fail++; $display("FAIL hold_map: got %0d expected 1", map_idx); end
    btn = 1'b0;
    x = 4'd4; y = 4'd6; #1;
    n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL map1_4_6: got %0b expected 1", wall); end
    x = 4'd12; y = 4'd6; #1;
    n_checks++; if (wall !== 1'b0) begin n_fail++; $display("FAIL map1_12_6: got %0b expected 0", wall); end
    x = 4'd11; y = 4'd6; #1;
    n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL map1_11_6: got %0b expected 1", wall); end
    x = 4'd8; y = 4'd3; #1;
    n_checks++; if (wall !== 1'b0) begin n_fail++; $display("FAIL map1_8_3: got %0b expected 0", wall); end
    tick();
  endtask

  task automatic test_lockout();
    do_reset();
    btn = 1'b1;
    repeat (3) tick();
    n_checks++; if (map_idx !== 2'd1) begin n_fail++; $display("FAIL lock_first: got %0d expected 1", map_idx); end
    btn = 1'b0;
    tick();
    btn = 1'b1;
    cnt = 0;
    repeat (8) begin tick(); cnt += int'(restart); end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL lock_discard: got %0d restarts expected 0", cnt); end
    n_checks++; if (map_idx !== 2'd1) begin n_fail++; $display("FAIL lock_map_held: got %0d expected 1", map_idx); end
    btn = 1'b0;
    repeat (8) tick();
    btn = 1'b1;
    repeat (3) tick();
    n_checks++; if (restart !== 1'b1) begin n_fail++; $display("FAIL lock_after_restart: got %0b expected 1", restart); end
    n_checks++; if (map_idx !== 2'd2) begin n_fail++; $display("FAIL lock_after_map: got %0d expected 2", map_idx); end
    btn = 1'b0;
    tick();
    n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL lock_pulse_width: got %0b expected 0", restart); end
    x = 4'd8; y = 4'd3; #1;
    n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL map2_8_3: got %0b expected 1", wall); end
    x = 4'd8; y = 4'd9; #1;
    n_checks++; if (wall !== 1'b0) begin n_fail++; $display("FAIL map2_8_9: got %0b expected 0", wall); end
    x = 4'd8; y = 4'd8; #1;
    n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL map2_8_8: got %0b expected 1", wall); end
    x = 4'd4; y = 4'd6; #1;
    n_checks++; if (wall !== 1'b0) begin n_fail++; $display("FAIL map2_4_6: got %0b expected 0", wall); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      btn = 1'b1;
      repeat (3) tick();
      n_checks++; if (map_idx !== 2'(i % 4)) begin n_fail++; $display("FAIL wrap_map_%0d: got %0d expected %0d", i, map_idx, i % 4); end
      n_checks++; if (restart !== 1'b1) begin n_fail++; $display("FAIL wrap_restart_%0d: got %0b expected 1", i, restart); end
      btn = 1'b0;
      if (i == 3) begin
        x = 4'd8; y = 4'd6; #1;
        n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL map3_8_6: got %0b expected 1", wall); end
        x = 4'd11; y = 4'd6; #1;
        n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL map3_11_6: got %0b expected 1", wall); end
        x = 4'd8; y = 4'd3; #1;
        n_checks++; if (wall !== 1'b1) begin n_fail++; $display("FAIL map3_8_3: got %0b expected 1", wall); end
        x = 4'd12; y = 4'd6; #1;
        n_checks++; if (wall !== 1'b0) begin n_fail++; $display("FAIL map3_12_6: got %0b expected 0", wall); end
      end
      repeat (6) tick();
    end
    x = 4'd8; y = 4'd6; #1;
    n_checks++; if (wall !== 1'b0) begin n_fail++; $display("FAIL map0_8_6: got %0b expected 0", wall); end
  endtask

  task automatic test_play();
    do_reset();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL play_start: got %0b expected 1", playing); end
    btn = 1'b1;
    cnt = 0;
    repeat (3) begin tick(); cnt += int'(restart); end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL play_press_restart: got %0d expected 0", cnt); end
    n_checks++; if (map_idx !== 2'd0) begin n_fail++; $display("FAIL play_press_map: got %0d expected 0", map_idx); end
    btn = 1'b0;
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL play_over: got %0b expected 0", playing); end
    btn = 1'b1;
    repeat (3) tick();
    n_checks++; if (restart !== 1'b1) begin n_fail++; $display("FAIL over_press_restart: got %0b expected 1", restart); end
    n_checks++; if (map_idx !== 2'd0) begin n_fail++; $display("FAIL over_press_map: got %0d expected 0", map_idx); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL over_press_playing: got %0b expected 0", playing); end
    btn = 1'b0;
    repeat (7) tick();
    btn = 1'b1;
    repeat (3) tick();
    n_checks++; if (map_idx !== 2'd1) begin n_fail++; $display("FAIL back_idle_map: got %0d expected 1", map_idx); end
    btn = 1'b0;
    tick();
  endtask

  task automatic test_start_and_press();
    do_reset();
    btn = 1'b1;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL sp_playing: got %0b expected 1", playing); end
    n_checks++; if (map_idx !== 2'd0) begin n_fail++; $display("FAIL sp_map: got %0d expected 0", map_idx); end
    n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL sp_restart: got %0b expected 0", restart); end
    btn = 1'b0;
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    btn = 1'b1;
    cnt = 0;
    repeat (6) begin tick(); cnt += int'(restart); end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL sp_lockout_loaded: got %0d restarts expected 0", cnt); end
    btn = 1'b0;
    repeat (6) tick();
    btn = 1'b1;
    repeat (3) tick();
    n_checks++; if (restart !== 1'b1) begin n_fail++; $display("FAIL sp_over_restart: got %0b expected 1", restart); end
    n_checks++; if (map_idx !== 2'd0) begin n_fail++; $display("FAIL sp_over_map: got %0d expected 0", map_idx); end
    btn = 1'b0;
    tick();
  endtask

  task automatic test_reset_midway();
    do_reset();
    btn = 1'b1;
    repeat (3) tick();
    n_checks++; if (map_idx !== 2'd1) begin n_fail++; $display("FAIL rm_pre_map: got %0d expected 1", map_idx); end
    btn = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (map_idx !== 2'd0) begin n_fail++; $display("FAIL rm_async_map: got %0d expected 0", map_idx); end
    tick();
    reset = 1'b0;
    btn = 1'b1;
    repeat (3) tick();
    n_checks++; if (restart !== 1'b1) begin n_fail++; $display("FAIL rm_press_restart: got %0b expected 1", restart); end
    n_checks++; if (map_idx !== 2'd1) begin n_fail++; $display("FAIL rm_press_map: got %0d expected 1", map_idx); end
    btn = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL rm_play: got %0b expected 1", playing); end
    reset = 1'b1;
    #1;
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL rm_play_reset: got %0b expected 0", playing); end
    n_checks++; if (map_idx !== 2'd0) begin n_fail++; $display("FAIL rm_play_map: got %0d expected 0", map_idx); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; btn = 1'b0; start = 1'b0; game_over = 1'b0; x = 4'd0; y = 4'd0;
    test_reset();
    test_hold();
    test_lockout();
    test_wrap();
    test_play();
    test_start_and_press();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
